// File: rtl/rtc_apb_master.sv
// Single-outstanding APB requester: one command in, one APB transfer out, one response back.
// Optional ACCESS-phase watchdog enabled by defining RTC_APB_TIMEOUT_EN.
module rtc_apb_master #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              CLK_APB,
  input  logic              rst_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_write_i,
  input  logic [ADDR_W-1:0] cmd_addr_i,
  input  logic [DATA_W-1:0] cmd_wdata_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_rdata_o,
  output logic              rsp_err_o,
  output logic              rsp_timeout_o,
  output logic              PSEL,
  output logic              PENABLE,
  output logic              PWRITE,
  output logic [ADDR_W-1:0] PADDR,
  output logic [DATA_W-1:0] PWDATA,
  input  logic [DATA_W-1:0] PRDATA,
  input  logic              PREADY,
  input  logic              PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  if ((TIMEOUT_CYC < 32'sd2) || (TIMEOUT_CYC > 32'sd255)) begin : g_bad_timeout_cyc
    $error("rtc_apb_master: TIMEOUT_CYC must be in 2..255");
  end

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;
  logic              w_complete;
  logic              w_tmo_hit;

  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;

  assign w_accept   = (r_state == ST_IDLE) && cmd_valid_i;
  assign w_complete = (r_state == ST_ACCESS) && PREADY;

  // State register
  always_ff @(posedge CLK_APB) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          w_state_nxt = ST_SETUP;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY || w_tmo_hit) begin
          w_state_nxt = ST_RESP;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESP;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Registered APB signals and response payload, all decoded from the next state
  always_ff @(posedge CLK_APB) begin
    if (rst_i) begin
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= {DATA_W{1'b0}};
      r_rsp_err   <= 1'b0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= {ADDR_W{1'b0}};
      r_pwdata    <= {DATA_W{1'b0}};
    end else begin
      r_cmd_ready <= (w_state_nxt == ST_IDLE);
      r_rsp_valid <= (w_state_nxt == ST_RESP);
      r_psel      <= (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
      r_penable   <= (w_state_nxt == ST_ACCESS);
      if (w_accept) begin
        r_pwrite <= cmd_write_i;
        r_paddr  <= cmd_addr_i;
        r_pwdata <= cmd_write_i ? cmd_wdata_i : {DATA_W{1'b0}};
      end else begin
        r_pwrite <= r_pwrite;
        r_paddr  <= r_paddr;
        r_pwdata <= r_pwdata;
      end
      // A timed-out transfer reports an error with no data
      if (w_complete) begin
        r_rsp_rdata <= r_pwrite ? {DATA_W{1'b0}} : PRDATA;
        r_rsp_err   <= PSLVERR;
      end else if (w_tmo_hit) begin
        r_rsp_rdata <= {DATA_W{1'b0}};
        r_rsp_err   <= 1'b1;
      end else begin
        r_rsp_rdata <= r_rsp_rdata;
        r_rsp_err   <= r_rsp_err;
      end
    end
  end

`ifdef RTC_APB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  logic [7:0] r_tmo_cnt;
  logic       r_rsp_timeout;

  assign w_tmo_hit = (r_state == ST_ACCESS) && !PREADY && (r_tmo_cnt == TMO_LAST);

  // Count stalled ACCESS cycles; cleared whenever a new transfer enters SETUP
  always_ff @(posedge CLK_APB) begin
    if (rst_i) begin
      r_tmo_cnt     <= 8'd0;
      r_rsp_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_tmo_cnt <= 8'd0;
      end else if ((r_state == ST_ACCESS) && !PREADY && !w_tmo_hit) begin
        r_tmo_cnt <= r_tmo_cnt + 8'd1;
      end else begin
        r_tmo_cnt <= r_tmo_cnt;
      end
      if (w_tmo_hit) begin
        r_rsp_timeout <= 1'b1;
      end else if (w_complete) begin
        r_rsp_timeout <= 1'b0;
      end else begin
        r_rsp_timeout <= r_rsp_timeout;
      end
    end
  end

  assign rsp_timeout_o = r_rsp_timeout;
`else
  assign w_tmo_hit     = 1'b0;
  assign rsp_timeout_o = 1'b0;
`endif

  assign cmd_ready_o = r_cmd_ready;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;

endmodule

// File: tb/tb_rtc_apb_master.sv
// Randomized self-checking bench for rtc_apb_master; expected cycle timing and response
// contents come from a transaction-level model (wait count -> ACCESS length -> response).
module tb_rtc_apb_master;

  localparam int ADDR_W  = 8;
  localparam int DATA_W  = 32;
  localparam int TMO_CYC = 4;
`ifdef RTC_APB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic              CLK_APB = 1'b0;
  logic              rst_i = 1'b1;
  logic              cmd_valid_i = 1'b0;
  logic              cmd_ready_o;
  logic              cmd_write_i = 1'b0;
  logic [ADDR_W-1:0] cmd_addr_i = '0;
  logic [DATA_W-1:0] cmd_wdata_i = '0;
  logic              rsp_valid_o;
  logic              rsp_ready_i = 1'b0;
  logic [DATA_W-1:0] rsp_rdata_o;
  logic              rsp_err_o;
  logic              rsp_timeout_o;
  logic              PSEL, PENABLE, PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA = '0;
  logic              PREADY = 1'b0;
  logic              PSLVERR = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  rtc_apb_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYC(TMO_CYC)) dut (
    .CLK_APB(CLK_APB), .rst_i(rst_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o), .cmd_write_i(cmd_write_i),
    .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_rdata_o(rsp_rdata_o),
    .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 CLK_APB = ~CLK_APB;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK_APB);
    #1;
  endtask

  // One full command: accept, SETUP, (w stalled + 1) ACCESS cycles or timeout, RESP held 'hold' cycles.
  task automatic run_txn(input bit wr, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd,
                         input int w, input logic [DATA_W-1:0] rd, input bit err, input int hold);
    bit                tmo;
    int                acc;
    logic [DATA_W-1:0] exp_rd;
    logic [DATA_W-1:0] exp_pwd;
    bit                exp_err;
    tmo     = TMO_EN && (w >= TMO_CYC);
    acc     = tmo ? TMO_CYC : w + 1;
    exp_rd  = (tmo || wr) ? '0 : rd;
    exp_err = tmo ? 1'b1 : err;
    exp_pwd = wr ? wd : '0;

    check_value("idle_cmd_ready", cmd_ready_o, 1);
    cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = wd;
    tick();
    cmd_valid_i = 1'b0; cmd_write_i = 1'($urandom);
    cmd_addr_i = ADDR_W'($urandom); cmd_wdata_i = $urandom;

    check_value("setup_psel", PSEL, 1);
    check_value("setup_penable", PENABLE, 0);
    check_value("setup_paddr", PADDR, addr);
    check_value("setup_pwrite", PWRITE, wr);
    check_value("setup_pwdata", PWDATA, exp_pwd);
    check_value("setup_cmd_ready", cmd_ready_o, 0);
    tick();

    for (int i = 0; i < acc; i++) begin
      check_value("access_psel", PSEL, 1);
      check_value("access_penable", PENABLE, 1);
      check_value("access_paddr", PADDR, addr);
      check_value("access_pwrite", PWRITE, wr);
      check_value("access_pwdata", PWDATA, exp_pwd);
      check_value("access_rsp_valid", rsp_valid_o, 0);
      PREADY  = (i == w);
      PRDATA  = (i == w) ? rd : $urandom;
      PSLVERR = (i == w) ? err : 1'($urandom);
      tick();
    end
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;

    for (int h = 0; h <= hold; h++) begin
      check_value("resp_valid", rsp_valid_o, 1);
      check_value("resp_rdata", rsp_rdata_o, exp_rd);
      check_value("resp_err", rsp_err_o, exp_err);
      check_value("resp_timeout", rsp_timeout_o, tmo);
      check_value("resp_psel", PSEL, 0);
      check_value("resp_penable", PENABLE, 0);
      check_value("resp_cmd_ready", cmd_ready_o, 0);
      check_value("resp_paddr_hold", PADDR, addr);
      rsp_ready_i = (h == hold);
      cmd_valid_i = (h < hold) ? 1'($urandom) : 1'b0;
      tick();
    end
    rsp_ready_i = 1'b0; cmd_valid_i = 1'b0;
    check_value("done_rsp_valid", rsp_valid_o, 0);
    check_value("done_cmd_ready", cmd_ready_o, 1);
    check_value("done_psel", PSEL, 0);
  endtask

  task automatic reset_mid_access();
    cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 8'h5A; cmd_wdata_i = 32'hDEAD_BEEF;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    tick();
    check_value("mid_penable", PENABLE, 1);
    rst_i = 1'b1;
    tick();
    check_value("rst_psel", PSEL, 0);
    check_value("rst_penable", PENABLE, 0);
    check_value("rst_rsp_valid", rsp_valid_o, 0);
    check_value("rst_paddr", PADDR, 0);
    check_value("rst_pwrite", PWRITE, 0);
    check_value("rst_pwdata", PWDATA, 0);
    check_value("rst_rdata", rsp_rdata_o, 0);
    check_value("rst_err", rsp_err_o, 0);
    check_value("rst_timeout", rsp_timeout_o, 0);
    rst_i = 1'b0;
    tick();
    check_value("post_rst_cmd_ready", cmd_ready_o, 1);
    check_value("post_rst_rsp_valid", rsp_valid_o, 0);
  endtask

  initial begin
    rst_i = 1'b1;
    tick();
    tick();
    check_value("reset_psel", PSEL, 0);
    check_value("reset_penable", PENABLE, 0);
    check_value("reset_rsp_valid", rsp_valid_o, 0);
    check_value("reset_paddr", PADDR, 0);
    check_value("reset_pwdata", PWDATA, 0);
    check_value("reset_rdata", rsp_rdata_o, 0);
    check_value("reset_err", rsp_err_o, 0);
    check_value("reset_timeout", rsp_timeout_o, 0);
    rst_i = 1'b0;
    tick();
    check_value("reset_cmd_ready", cmd_ready_o, 1);

    run_txn(1'b1, 8'h04, 32'h0000_0001, 0, 32'h0, 1'b0, 0);
    run_txn(1'b0, 8'h10, 32'hFFFF_FFFF, 3, 32'h0000_0017, 1'b0, 0);
    run_txn(1'b0, 8'h22, 32'h0, 1, 32'hCAFE_0001, 1'b1, 5);
    run_txn(1'b0, 8'h30, 32'h0, 55, 32'h1234_5678, 1'b0, 1);
    run_txn(1'b1, 8'h31, 32'hA5A5_5A5A, TMO_CYC - 1, 32'h0, 1'b0, 0);

    reset_mid_access();
    run_txn(1'b1, 8'h08, 32'h0000_00FF, 0, 32'h0, 1'b0, 0);

    for (int k = 0; k < 40; k++) begin
      run_txn(1'($urandom), ADDR_W'($urandom), $urandom, $urandom_range(0, 6),
              $urandom, 1'($urandom), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rtc_apb_master.md
RTC_APB_MASTER -- requirements
Module: rtc_apb_master

Interface
REQ-001 The module SHALL have parameter ADDR_W, default 8, APB address width.
REQ-002 The module SHALL have parameter DATA_W, default 32, APB data width.
REQ-003 The module SHALL have parameter TIMEOUT_CYC, default 16, range 2..255, maximum ACCESS cycles before abort (used only with RTC_APB_TIMEOUT_EN).
REQ-004 The module SHALL have port CLK_APB  input  1  single clock; all logic on its rising edge.
REQ-005 The module SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-006 The module SHALL have port cmd_valid_i  input  1  command request.
REQ-007 The module SHALL have port cmd_ready_o  output  1  command accepted when high with cmd_valid_i.
REQ-008 The module SHALL have port cmd_write_i  input  1  1=write, 0=read.
REQ-009 The module SHALL have port cmd_addr_i  input  ADDR_W  target register address.
REQ-010 The module SHALL have port cmd_wdata_i  input  DATA_W  write data.
REQ-011 The module SHALL have port rsp_valid_o  output  1  response available.
REQ-012 The module SHALL have port rsp_ready_i  input  1  response consumed when high with rsp_valid_o.
REQ-013 The module SHALL have ports rsp_rdata_o  output  DATA_W  read data, and rsp_err_o  output  1  PSLVERR or timeout.
REQ-014 The module SHALL have port rsp_timeout_o  output  1  transfer aborted by timeout.
REQ-015 The module SHALL have APB requester ports PSEL, PENABLE, PWRITE (output, 1), PADDR (output, ADDR_W), PWDATA (output, DATA_W), PRDATA (input, DATA_W), PREADY, PSLVERR (input, 1).

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, ACCESS, RESP; cmd_ready_o SHALL be 1 only in IDLE.
REQ-017 On cmd_valid_i & cmd_ready_o at edge N, the block SHALL register write/addr/wdata and enter SETUP at N+1 (PSEL=1, PENABLE=0).
REQ-018 From SETUP the block SHALL enter ACCESS unconditionally next cycle (PSEL=1, PENABLE=1).
REQ-019 In ACCESS, PREADY=1 SHALL complete the transfer: capture PRDATA (reads) or 0 (writes) into rsp_rdata_o, PSLVERR into rsp_err_o, enter RESP; PREADY=0 SHALL hold ACCESS.
REQ-020 PADDR, PWRITE, PWDATA SHALL be stable from SETUP through the last ACCESS cycle; PWDATA SHALL be 0 for reads; PADDR/PWRITE SHALL hold last value in IDLE/RESP.
REQ-021 PSEL and PENABLE SHALL be 0 in IDLE and RESP.
REQ-022 In RESP, rsp_valid_o SHALL be 1 with rsp_rdata_o/rsp_err_o/rsp_timeout_o stable until rsp_ready_i=1, then IDLE next cycle.
REQ-023 Minimum latency: accept at N, PREADY=1 in first ACCESS (N+2), rsp_valid_o=1 at N+3; back-to-back next accept no earlier than N+4 with rsp_ready_i=1 at N+3.
REQ-024 cmd_* inputs outside an accept cycle SHALL be ignored; no command queueing.

Reset
REQ-025 rst_i=1 at any edge, including mid-transfer, SHALL force IDLE and zero PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_timeout_o and the timeout counter; cmd_ready_o SHALL be 1 the cycle after reset deasserts; any in-flight response SHALL be discarded.

Configuration
REQ-026 With macro RTC_APB_TIMEOUT_EN defined, a counter SHALL count ACCESS cycles with PREADY=0; on reaching TIMEOUT_CYC the block SHALL drop PSEL/PENABLE, enter RESP with rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0; counter SHALL clear on entering SETUP.
REQ-027 Without RTC_APB_TIMEOUT_EN, no counter SHALL exist, rsp_timeout_o SHALL be tied 0, and ACCESS SHALL wait indefinitely for PREADY.

Verification
REQ-028 Write addr 0x04 data 0x0000_0001, PREADY=1 immediate -> PSEL at N+1, PENABLE at N+2, PWDATA=0x1 throughout, rsp_valid_o at N+3, rsp_err_o=0.
REQ-029 Read addr 0x10, PREADY low 3 ACCESS cycles then high with PRDATA=0x0000_0017 -> PADDR stable 0x10, rsp_rdata_o=0x17 at N+6.
REQ-030 Read with PSLVERR=1 at completion -> rsp_err_o=1, rsp_timeout_o=0; rsp_ready_i held 0 for 5 cycles -> rsp_valid_o and data stable, no new accept.
REQ-031 RTC_APB_TIMEOUT_EN, TIMEOUT_CYC=4, PREADY stuck 0 -> PSEL drops after 4 ACCESS cycles, rsp_err_o=1, rsp_timeout_o=1, rsp_rdata_o=0; without macro -> ACCESS held 50+ cycles.
REQ-032 rst_i=1 during ACCESS -> next edge PSEL=PENABLE=0, rsp_valid_o=0, cmd_ready_o=1 after release; following write completes normally.
